// File: rtl/fifo_read_slave.sv
// fifo_read_slave: single-clock FIFO, slave side of the FIFO read interface.
// Define FIFO_READ_SLAVE_FWFT_EN for first-word fall-through read timing.
module fifo_read_slave #(
    parameter int DATA_WIDTH          = 32,
    parameter int DEPTH               = 16,
    parameter int ALMOST_EMPTY_THRESH = 1,
    parameter int ALMOST_FULL_THRESH  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       almost_full,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_en,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] AE_L   = LW'(ALMOST_EMPTY_THRESH);
    localparam logic [LW-1:0] AF_L   = LW'(DEPTH - ALMOST_FULL_THRESH);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  empty_q, aempty_q, full_q, afull_q;
    logic                  ovf_q, unf_q;
    logic                  push, pop;

    // Accept decisions, pointer/level next state and next read word
    always_comb begin
        push   = wr_en && !full_q;
        pop    = rd_en && !empty_q;
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
`ifdef FIFO_READ_SLAVE_FWFT_EN
        // Head word after this cycle; bypass when it is being written now
        if (level_d == '0) begin
            rd_data_d = '0;
        end else if (push && (wptr_q == rptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rptr_d];
        end
`else
        rd_data_d = pop ? mem_q[rptr_q] : rd_data_q;
`endif
    end

    // Storage array; never cleared, contents simply abandoned on reset
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Pointers, level, read register and flags derived from next level
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            empty_q   <= (level_d == '0);
            aempty_q  <= (level_d <= AE_L);
            full_q    <= (level_d == FULL_L);
            afull_q   <= (level_d >= AF_L);
            ovf_q     <= wr_en && full_q;
            unf_q     <= rd_en && empty_q;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign rd_data      = rd_data_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_read_slave.sv
// tb_fifo_read_slave: directed checks of fifo_read_slave, DEPTH=16,
// both thresholds 2; follows FIFO_READ_SLAVE_FWFT_EN when defined.
module tb_fifo_read_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        full;
    logic        almost_full;
    logic [31:0] rd_data;
    logic        rd_en;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    int vec = 0;
    int bad = 0;

    fifo_read_slave #(
        .DATA_WIDTH(32),
        .DEPTH(16),
        .ALMOST_EMPTY_THRESH(2),
        .ALMOST_FULL_THRESH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .almost_full(almost_full),
        .rd_data(rd_data),
        .rd_en(rd_en),
        .empty(empty),
        .almost_empty(almost_empty),
        .level(level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock with the given requests; w is the word a pop returns
    task automatic cyc(input logic we, input logic [31:0] wd,
                       input logic re, output logic [31:0] w);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
`ifdef FIFO_READ_SLAVE_FWFT_EN
        w = rd_data;
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifndef FIFO_READ_SLAVE_FWFT_EN
        w = rd_data;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({level, empty, almost_empty, full, almost_full, overflow,
             underflow} !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_flags: got lvl=%0d e=%b ae=%b f=%b af=%b o=%b u=%b",
                     level, empty, almost_empty, full, almost_full,
                     overflow, underflow);
        end
        vec++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] w;
        logic [4:0]  lv;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 32'(i), 1'b0, w);
            lv = 5'(i);
            vec++;
            if ({level, empty, almost_empty, full, almost_full} !==
                {lv, 1'b0, lv <= 5'd2, lv == 5'd16, lv >= 5'd14}) begin
                bad++;
                $display("FAIL fill_%0d: got lvl=%0d e=%b ae=%b f=%b af=%b",
                         i, level, empty, almost_empty, full, almost_full);
            end
        end
        cyc(1'b1, 32'h11, 1'b0, w);
        vec++;
        if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16}) begin
            bad++;
            $display("FAIL overflow_push: got o=%b f=%b lvl=%0d expected 1 1 16",
                     overflow, full, level);
        end
        cyc(1'b0, 32'h0, 1'b0, w);
        vec++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_pulse: got %b expected 0", overflow);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 32'h0, 1'b1, w);
            vec++;
            if (w !== 32'(i)) begin
                bad++;
                $display("FAIL drain_data_%0d: got %h expected %h", i, w, i);
            end
            lv = 5'(16 - i);
            vec++;
            if ({level, empty, almost_empty, full, almost_full} !==
                {lv, lv == 5'd0, lv <= 5'd2, 1'b0, lv >= 5'd14}) begin
                bad++;
                $display("FAIL drain_%0d: got lvl=%0d e=%b ae=%b f=%b af=%b",
                         i, level, empty, almost_empty, full, almost_full);
            end
        end
    endtask

    task automatic test_empty_read();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1, w);
            vec++;
            if ({underflow, level, rd_data} !== {1'b1, 5'd0, 32'h0}) begin
                bad++;
                $display("FAIL empty_read_%0d: got u=%b lvl=%0d rd=%h expected 1 0 0",
                         i, underflow, level, rd_data);
            end
        end
        cyc(1'b0, 32'h0, 1'b0, w);
        vec++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse: got %b expected 0", underflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] w;
        logic [31:0] exp5 [6];
        exp5 = '{32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'hAA};
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h21 + 32'(i), 1'b0, w);
        cyc(1'b1, 32'hAA, 1'b1, w);
        vec++;
        if ({level, w} !== {5'd5, 32'h21}) begin
            bad++;
            $display("FAIL pushpop_mid: got lvl=%0d rd=%h expected 5 00000021",
                     level, w);
        end
        for (int i = 1; i < 6; i++) begin
            cyc(1'b0, 32'h0, 1'b1, w);
            vec++;
            if (w !== exp5[i]) begin
                bad++;
                $display("FAIL pushpop_order_%0d: got %h expected %h",
                         i, w, exp5[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0, w);
        cyc(1'b1, 32'hBB, 1'b1, w);
        vec++;
        if ({level, full, overflow, w} !== {5'd15, 1'b0, 1'b1, 32'h30}) begin
            bad++;
            $display("FAIL pushpop_full: got lvl=%0d f=%b o=%b rd=%h expected 15 0 1 00000030",
                     level, full, overflow, w);
        end
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 32'h0, 1'b1, w);
            vec++;
            if (w !== 32'h30 + 32'(i)) begin
                bad++;
                $display("FAIL full_drain_%0d: got %h expected %h",
                         i, w, 32'h30 + 32'(i));
            end
        end
        vec++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL full_drain_empty: got %b expected 1", empty);
        end
        do_reset();
        cyc(1'b1, 32'hCC, 1'b1, w);
        vec++;
        if ({level, empty, underflow} !== {5'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL pushpop_empty: got lvl=%0d e=%b u=%b expected 1 0 1",
                     level, empty, underflow);
        end
        cyc(1'b0, 32'h0, 1'b1, w);
        vec++;
        if (w !== 32'hCC) begin
            bad++;
            $display("FAIL pushpop_empty_data: got %h expected 000000cc", w);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        logic [31:0] q[$];
        logic [31:0] exp_w;
        logic [31:0] nxt;
        logic        we, re;
        do_reset();
        nxt = 32'h100;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, nxt, 1'b0, w);
            q.push_back(nxt);
            nxt++;
        end
        for (int c = 0; c < 40; c++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            if (q.size() >= 15 && !re) we = 1'b0;
            if (q.size() <= 1) re = 1'b0;
            exp_w = 32'h0;
            if (re) exp_w = q.pop_front();
            if (we) begin
                q.push_back(nxt);
            end
            cyc(we, nxt, re, w);
            if (we) nxt++;
            if (re) begin
                vec++;
                if (w !== exp_w) begin
                    bad++;
                    $display("FAIL wrap_data_%0d: got %h expected %h",
                             c, w, exp_w);
                end
            end
            vec++;
            if ({level, empty, full} !== {5'(q.size()), 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL wrap_level_%0d: got lvl=%0d e=%b f=%b expected %0d 0 0",
                         c, level, empty, full, q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h70 + 32'(i), 1'b0, w);
        cyc(1'b0, 32'h0, 1'b1, w);
        vec++;
        if ({level, w} !== {5'd9, 32'h70}) begin
            bad++;
            $display("FAIL pre_reset: got lvl=%0d rd=%h expected 9 00000070",
                     level, w);
        end
        do_reset();
        vec++;
        if ({level, empty, rd_data} !== {5'd0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL mid_reset: got lvl=%0d e=%b rd=%h expected 0 1 0",
                     level, empty, rd_data);
        end
        cyc(1'b1, 32'h55, 1'b0, w);
        vec++;
        if ({level, empty} !== {5'd1, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_push: got lvl=%0d e=%b expected 1 0",
                     level, empty);
        end
`ifdef FIFO_READ_SLAVE_FWFT_EN
        w = rd_data;
`else
        cyc(1'b0, 32'h0, 1'b1, w);
`endif
        vec++;
        if (w !== 32'h55) begin
            bad++;
            $display("FAIL post_reset_data: got %h expected 00000055", w);
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 32'h0;
        test_reset();
        test_fill_drain();
        test_empty_read();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
